// File: rtl/array_stream_unflatten.sv
// Receive end of an array-flattening link: reassembles a row-major element stream
// into a registered ROWS x COLS array with valid/ready on both sides and length checking.
module array_stream_unflatten #(
  parameter int WIDTH = 4,
  parameter int ROWS  = 3,
  parameter int COLS  = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  input  logic             in_last,
  output logic             in_ready,
  output logic [WIDTH-1:0] out_data [ROWS-1:0][COLS-1:0],
  output logic             out_valid,
  input  logic             out_ready,
  output logic             err
);

  localparam int N  = ROWS * COLS;
  localparam int CW = (N > 1) ? $clog2(N) : 1;

  localparam logic [0:0] FILL = 1'b0;
  localparam logic [0:0] FULL = 1'b1;

  logic [0:0]    state_q, state_d;
  logic [CW-1:0] idx_q, idx_d;
  logic          err_q, err_d;
  logic          accept, handoff, last_slot;

  assign out_valid = (state_q == FULL);
  assign err       = err_q;
  assign in_ready  = !out_valid || out_ready;
  assign accept    = in_valid && in_ready;
  assign handoff   = out_valid && out_ready;
  assign last_slot = (idx_q == CW'(N - 1));

  // idx is always 0 while FULL, so an accept during handoff naturally lands in slot 0
  // and is then treated exactly like a FILL-state accept.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    err_d   = 1'b0;
    if (handoff) state_d = FILL;
    if (accept) begin
      if (last_slot) begin
        state_d = FULL;
        idx_d   = '0;
        err_d   = !in_last;
      end else if (in_last) begin
        idx_d   = '0;
        err_d   = 1'b1;
      end else begin
        idx_d   = idx_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= FILL;
      idx_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      err_q   <= err_d;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned r = 0; r < ROWS; r++)
        for (int unsigned c = 0; c < COLS; c++)
          out_data[r][c] <= '0;
    end else if (accept) begin
      for (int unsigned r = 0; r < ROWS; r++)
        for (int unsigned c = 0; c < COLS; c++)
          if (idx_q == CW'(r * COLS + c))
            out_data[r][c] <= in_data;
    end
  end

endmodule

// File: tb/tb_array_stream_unflatten.sv
// Bench for array_stream_unflatten: directed scenarios followed by random traffic,
// checked every cycle against a queue-based frame model.
module tb_array_stream_unflatten;

  localparam int WIDTH = 4;
  localparam int ROWS  = 3;
  localparam int COLS  = 2;
  localparam int N     = ROWS * COLS;

  logic             clk = 1'b0;
  logic             rst;
  logic [WIDTH-1:0] in_data;
  logic             in_valid;
  logic             in_last;
  logic             in_ready;
  logic [WIDTH-1:0] out_data [ROWS-1:0][COLS-1:0];
  logic             out_valid;
  logic             out_ready;
  logic             err;

  array_stream_unflatten #(.WIDTH(WIDTH), .ROWS(ROWS), .COLS(COLS)) dut (
    .clk(clk), .rst(rst),
    .in_data(in_data), .in_valid(in_valid), .in_last(in_last), .in_ready(in_ready),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready), .err(err)
  );

  always #5 clk = ~clk;

  int unsigned errors = 0;
  int unsigned checks = 0;

  // Model: elements of the current partial frame, the visible slot contents,
  // and whether a completed frame is waiting for the consumer.
  logic [WIDTH-1:0] pend [$];
  logic [WIDTH-1:0] mem  [N];
  logic             m_valid;
  logic             m_err;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    pend.delete();
    for (int i = 0; i < N; i++) mem[i] = '0;
    m_valid = 1'b0;
    m_err   = 1'b0;
  endtask

  task automatic check_outputs(input string tag);
    logic [N*WIDTH-1:0] got, exp;
    for (int r = 0; r < ROWS; r++)
      for (int c = 0; c < COLS; c++) begin
        got[(r*COLS+c)*WIDTH +: WIDTH] = out_data[r][c];
        exp[(r*COLS+c)*WIDTH +: WIDTH] = mem[r*COLS+c];
      end
    chk({tag, ".out_valid"}, 32'(out_valid), 32'(m_valid));
    chk({tag, ".err"},       32'(err),       32'(m_err));
    chk({tag, ".out_data"},  32'(got),       32'(exp));
  endtask

  // One clock cycle: drive inputs, check ready, clock, advance model, check outputs.
  task automatic step(input string tag, input logic v, input logic [WIDTH-1:0] d,
                      input logic l, input logic ordy);
    logic exp_ready, acc;
    in_valid  = v;
    in_data   = d;
    in_last   = l;
    out_ready = ordy;
    #1;
    exp_ready = !m_valid || ordy;
    chk({tag, ".in_ready"}, 32'(in_ready), 32'(exp_ready));
    acc = v && exp_ready;
    @(posedge clk);
    if (m_valid && ordy) m_valid = 1'b0;
    m_err = 1'b0;
    if (acc) begin
      mem[pend.size()] = d;
      pend.push_back(d);
      if (pend.size() == N) begin
        m_valid = 1'b1;
        m_err   = !l;
        pend.delete();
      end else if (l) begin
        m_err = 1'b1;
        pend.delete();
      end
    end
    #1;
    check_outputs(tag);
  endtask

  task automatic frame(input string tag, input int base, input logic last_ok, input logic ordy);
    for (int k = 0; k < N; k++)
      step(tag, 1'b1, 4'(base + k), (k == N-1) ? last_ok : 1'b0, ordy);
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_data = '0; in_last = 1'b0; out_ready = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_outputs("reset");
    rst = 1'b0;

    // 1: single frame 1..6, consumer always ready
    frame("t1", 1, 1'b1, 1'b1);
    step("t1.drain", 1'b0, '0, 1'b0, 1'b1);

    // 2: frame with consumer stalled; offered elements must be ignored
    frame("t2", 1, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) step("t2.stall", 1'b1, 4'hf, 1'b1, 1'b0);
    step("t2.handoff", 1'b0, '0, 1'b0, 1'b1);
    step("t2.idle", 1'b0, '0, 1'b0, 1'b1);

    // 3: back-to-back frames 0..5 and 10..15
    frame("t3a", 0, 1'b1, 1'b1);
    frame("t3b", 10, 1'b1, 1'b1);
    step("t3.drain", 1'b0, '0, 1'b0, 1'b1);

    // 4: early end on third element, then a good frame
    step("t4", 1'b1, 4'd7, 1'b0, 1'b1);
    step("t4", 1'b1, 4'd8, 1'b0, 1'b1);
    step("t4.early", 1'b1, 4'd9, 1'b1, 1'b1);
    frame("t4.next", 1, 1'b1, 1'b1);
    step("t4.drain", 1'b0, '0, 1'b0, 1'b1);

    // 5: missing last on sixth element
    frame("t5", 3, 1'b0, 1'b1);
    step("t5.drain", 1'b0, '0, 1'b0, 1'b1);

    // 6: reset after four accepted elements
    for (int k = 0; k < 4; k++) step("t6.pre", 1'b1, 4'(k + 11), 1'b0, 1'b1);
    rst = 1'b1;
    #1;
    model_reset();
    check_outputs("t6.rst");
    rst = 1'b0;
    frame("t6.post", 1, 1'b1, 1'b1);
    step("t6.drain", 1'b0, '0, 1'b0, 1'b1);

    // random traffic with occasional length errors and consumer stalls
    for (int i = 0; i < 400; i++) begin
      logic v, l, r;
      v = ($urandom_range(0, 9) < 7);
      r = ($urandom_range(0, 9) < 6);
      if (pend.size() == N-1) l = ($urandom_range(0, 9) < 8);
      else                    l = ($urandom_range(0, 19) == 0);
      step("rand", v, 4'($urandom), l, r);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
